// File: rtl/reg_file_wb.sv
// reg_file_wb: 32 x 32 architectural register file, writeback side.
// Ports: clk/rst (sync, active high); write port wr_en/wr_addr/wr_link/wr_data
// with stall deferral (wr_pending); two combinational read ports rd_addrN/rd_dataN;
// registered debug read port dbg_addr/dbg_data.
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_link,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              wr_pending
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] dest;
    logic              direct;
    logic              hold_commit;
    logic              capture;
    logic [NREG-1:0]   dir_stb;
    logic [NREG-1:0]   hold_stb;

    assign dest        = wr_link ? LINK_A : wr_addr;
    assign direct      = wr_en && !stall;
    assign hold_commit = wr_pending && !stall;
    // A new write while a write is already held and stalled is dropped.
    assign capture     = stall && wr_en && !wr_pending;

    assign dir_stb  = direct ? (NREG'(1) << dest) : '0;
    assign hold_stb = hold_commit ? (NREG'(1) << hold_addr) : '0;

    // Direct strobe checked first: the new write is younger than the held one.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i != 0) begin
                    if (dir_stb[i])
                        regs[i] <= wr_data;
                    else if (hold_stb[i])
                        regs[i] <= hold_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pending <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
        end else if (capture) begin
            wr_pending <= 1'b1;
            hold_addr  <= dest;
            hold_data  <= wr_data;
        end else if (hold_commit) begin
            wr_pending <= 1'b0;
        end
    end

    // Samples the array before any write landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            dbg_data <= '0;
        else
            dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (rd_addr1 == '0)
            rd_data1 = '0;
        else if (BYPASS != 0 && direct && rd_addr1 == dest)
            rd_data1 = wr_data;
        else if (BYPASS != 0 && wr_pending && rd_addr1 == hold_addr)
            rd_data1 = hold_data;
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (rd_addr2 == '0)
            rd_data2 = '0;
        else if (BYPASS != 0 && direct && rd_addr2 == dest)
            rd_data2 = wr_data;
        else if (BYPASS != 0 && wr_pending && rd_addr2 == hold_addr)
            rd_data2 = hold_data;
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed table plus randomized run against a
// behavioural register-file model for reg_file_wb.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst, wr_en, wr_link, stall;
    logic [4:0]  wr_addr, rd_addr1, rd_addr2, dbg_addr;
    logic [31:0] wr_data, rd_data1, rd_data2, dbg_data;
    logic        wr_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_wb dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_link(wr_link), .wr_data(wr_data), .stall(stall),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .wr_pending(wr_pending)
    );

    // Upstream must not issue a write while a held write is still stalled.
    always @(posedge clk)
        if (!rst)
            assert (!(stall && wr_pending && wr_en))
                else $error("FAIL protocol: wr_en during stalled pending write");

    typedef struct {
        logic        rst, we, lk, st;
        logic [4:0]  wa, a1, a2, da;
        logic [31:0] wd;
        logic [31:0] e1, e2;
        logic        ep;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(
        input logic rs, we, lk, st,
        input logic [4:0] wa, input logic [31:0] wd,
        input logic [4:0] a1, a2, da,
        input logic [31:0] e1, e2,
        input logic ep, input logic [31:0] ed);
        vec_t v;
        v.rst = rs; v.we = we; v.lk = lk; v.st = st;
        v.wa = wa; v.wd = wd; v.a1 = a1; v.a2 = a2; v.da = da;
        v.e1 = e1; v.e2 = e2; v.ep = ep; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: architectural state plus at most one deferred write.
    logic [31:0] m [32];
    bit          mp;
    logic [4:0]  mha;
    logic [31:0] mhd;

    function automatic logic [31:0] exp_rd(
        input logic [4:0] a, input logic we, st,
        input logic [4:0] d, input logic [31:0] wd);
        if (a == 0) return 0;
        if (we && !st && a == d) return wd;
        if (mp && a == mha) return mhd;
        return m[a];
    endfunction

    initial begin
        //          rs we lk st wa  wd            a1  a2  da  e1            e2            ep  ed
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        0,  0,  0,  32'h0,        32'h0,        0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 0, 5, 32'hDEADBEEF, 5,  0,  5,  32'hDEADBEEF, 32'h0,        0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0,        5,  0,  5,  32'hDEADBEEF, 32'h0,        0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,        5,  5,  5,  32'h0,        32'h0,        0, 32'h0);
        tbl[4]  = mk(0, 1, 0, 0, 7, 32'h12345678, 0,  7,  7,  32'h0,        32'h12345678, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 32'h0,        0,  7,  7,  32'h0,        32'h12345678, 0, 32'h12345678);
        tbl[6]  = mk(0, 1, 1, 0, 3, 32'h00400010, 31, 3,  3,  32'h00400010, 32'h0,        0, 32'h0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0,        31, 3,  31, 32'h00400010, 32'h0,        0, 32'h00400010);
        tbl[8]  = mk(0, 1, 0, 0, 0, 32'hFFFFFFFF, 0,  0,  0,  32'h0,        32'h0,        0, 32'h0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 32'h0,        0,  0,  0,  32'h0,        32'h0,        0, 32'h0);
        tbl[10] = mk(0, 1, 0, 1, 9, 32'hA5A5A5A5, 9,  0,  9,  32'h0,        32'h0,        1, 32'h0);
        tbl[11] = mk(0, 0, 0, 1, 0, 32'h0,        9,  0,  9,  32'hA5A5A5A5, 32'h0,        1, 32'h0);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        9,  0,  9,  32'hA5A5A5A5, 32'h0,        0, 32'h0);
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,        9,  0,  9,  32'hA5A5A5A5, 32'h0,        0, 32'hA5A5A5A5);
        tbl[14] = mk(0, 1, 0, 1, 9, 32'h1,        9,  0,  9,  32'hA5A5A5A5, 32'h0,        1, 32'hA5A5A5A5);
        tbl[15] = mk(0, 1, 0, 0, 9, 32'h2,        9,  9,  9,  32'h2,        32'h2,        0, 32'hA5A5A5A5);
        tbl[16] = mk(0, 0, 0, 0, 0, 32'h0,        9,  0,  9,  32'h2,        32'h0,        0, 32'h2);
        tbl[17] = mk(0, 1, 0, 1, 4, 32'h55,       4,  0,  4,  32'h0,        32'h0,        1, 32'h0);
        tbl[18] = mk(1, 0, 0, 1, 0, 32'h0,        4,  0,  4,  32'h55,       32'h0,        0, 32'h0);
        tbl[19] = mk(0, 0, 0, 0, 0, 32'h0,        4,  0,  4,  32'h0,        32'h0,        0, 32'h0);
        tbl[20] = mk(0, 0, 0, 0, 0, 32'h0,        4,  0,  4,  32'h0,        32'h0,        0, 32'h0);

        rst = 0; wr_en = 0; wr_link = 0; stall = 0; wr_addr = 0;
        wr_data = 0; rd_addr1 = 0; rd_addr2 = 0; dbg_addr = 0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; wr_en = tbl[i].we; wr_link = tbl[i].lk;
            stall = tbl[i].st; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_addr1 = tbl[i].a1; rd_addr2 = tbl[i].a2; dbg_addr = tbl[i].da;
            #1;
            chk($sformatf("vec%0d rd_data1", i), rd_data1, tbl[i].e1);
            chk($sformatf("vec%0d rd_data2", i), rd_data2, tbl[i].e2);
            @(posedge clk); #1;
            chk($sformatf("vec%0d wr_pending", i), {31'b0, wr_pending}, {31'b0, tbl[i].ep});
            chk($sformatf("vec%0d dbg_data", i), dbg_data, tbl[i].ed);
        end

        // Randomized run; the first cycle resets both DUT and model.
        for (int c = 0; c < 2000; c++) begin
            logic [4:0]  d;
            logic [31:0] edbg;
            @(negedge clk);
            rst     = (c == 0) || ($urandom_range(0, 63) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 2) != 0);
            if (!rst && mp && stall) wr_en = 0;
            wr_link = ($urandom_range(0, 7) == 0);
            wr_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data = $urandom;
            rd_addr1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rd_addr2 = $urandom_range(0, 1) ? wr_addr : 5'($urandom);
            dbg_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            d = wr_link ? 5'd31 : wr_addr;
            #1;
            if (c != 0) begin
                chk("rand rd_data1", rd_data1, exp_rd(rd_addr1, wr_en, stall, d, wr_data));
                chk("rand rd_data2", rd_data2, exp_rd(rd_addr2, wr_en, stall, d, wr_data));
            end
            edbg = (dbg_addr == 0) ? 32'h0 : m[dbg_addr];
            if (rst) begin
                for (int k = 0; k < 32; k++) m[k] = 0;
                mp = 0;
                edbg = 0;
            end else if (!stall) begin
                if (mp && mha != 0) m[mha] = mhd;
                mp = 0;
                if (wr_en && d != 0) m[d] = wr_data;
            end else if (wr_en && !mp) begin
                mp = 1; mha = d; mhd = wr_data;
            end
            @(posedge clk); #1;
            chk("rand wr_pending", {31'b0, wr_pending}, {31'b0, mp});
            chk("rand dbg_data", dbg_data, edbg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
